// File: rtl/pipe_control_unit_if.sv
// Control-unit bundle: the decode input (instruction in D, E-stage zero flag)
// and every per-stage control, hazard and forwarding output.
// Flow control: there is no valid/ready pair on this bundle. Every pipeline
// register advances on each clock; stall_f/stall_d hold the PC and F/D
// registers, flush_d clears F/D, and the control unit inserts E-stage bubbles
// internally. A consumer must honour stall_*/flush_d on the same cycle they
// are asserted.
interface pipe_control_unit_if #(
  parameter int ALUCTRL_W = 4,
  parameter int IMMSRC_W  = 3
);
  logic [31:0]          instr_d;
  logic                 zero_e;
  logic [IMMSRC_W-1:0]  immsrc_d;
  logic                 regwrite_e, regwrite_m, regwrite_w;
  logic [1:0]           resultsrc_e, resultsrc_m, resultsrc_w;
  logic                 memwrite_e, memwrite_m;
  logic                 alusrc_e;
  logic [ALUCTRL_W-1:0] alucontrol_e;
  logic                 pcsrc_e;
  logic [4:0]           rd_e, rd_m, rd_w;
  logic [4:0]           rs1_e, rs2_e;
  logic                 illegal_e;
  logic                 stall_f, stall_d, flush_d;
  logic [1:0]           fwd_a_e, fwd_b_e;

  modport master (
    output instr_d, zero_e,
    input  immsrc_d, regwrite_e, regwrite_m, regwrite_w,
           resultsrc_e, resultsrc_m, resultsrc_w, memwrite_e, memwrite_m,
           alusrc_e, alucontrol_e, pcsrc_e, rd_e, rd_m, rd_w, rs1_e, rs2_e,
           illegal_e, stall_f, stall_d, flush_d, fwd_a_e, fwd_b_e
  );

  modport slave (
    input  instr_d, zero_e,
    output immsrc_d, regwrite_e, regwrite_m, regwrite_w,
           resultsrc_e, resultsrc_m, resultsrc_w, memwrite_e, memwrite_m,
           alusrc_e, alucontrol_e, pcsrc_e, rd_e, rd_m, rd_w, rs1_e, rs2_e,
           illegal_e, stall_f, stall_d, flush_d, fwd_a_e, fwd_b_e
  );
endinterface

// File: rtl/pipe_control_unit.sv
// Control unit for a 5-stage RV32I pipeline: decodes the instruction in D,
// carries its control word through ID/EX, EX/MEM and MEM/WB, and produces the
// load-use stall, branch/jump flush and E-stage forwarding selects.
module pipe_control_unit #(
  parameter int ALUCTRL_W = 4,
  parameter int IMMSRC_W  = 3,
  parameter int FWD_EN    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_control_unit_if.slave bus
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010,
                         ALU_OR  = 4'b0011, ALU_XOR = 4'b0100, ALU_SLT = 4'b0101,
                         ALU_SLL = 4'b0110, ALU_SRL = 4'b0111, ALU_SRA = 4'b1000,
                         ALU_PASSB = 4'b1001;

  // Control word carried from D into E; an all-zero word is a bubble.
  typedef struct packed {
    logic       regwrite;
    logic [1:0] resultsrc;
    logic       memwrite;
    logic       branch;
    logic       jump;
    logic       alusrc;
    logic [3:0] aluctrl;
    logic       illegal;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ctrl_t;

  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic       w_f7b5;
  logic       w_is_r;
  logic [3:0] w_alufn;
  logic [2:0] w_immsrc_d;
  logic       w_use_rs1_d, w_use_rs2_d;
  ctrl_t      w_ctrl_d;
  logic       w_pcsrc_e, w_lwstall, w_bubble;
  logic       w_unused_bits;

  ctrl_t      r_ctrl_e;
  logic       r_regwrite_m, r_memwrite_m, r_regwrite_w;
  logic [1:0] r_resultsrc_m, r_resultsrc_w;
  logic [4:0] r_rd_m, r_rd_w;

  assign w_op   = bus.instr_d[6:0];
  assign w_f3   = bus.instr_d[14:12];
  assign w_f7b5 = bus.instr_d[30];
  assign w_is_r = (w_op == OP_R);
  // funct7 bits other than bit 5 never influence decode.
  assign w_unused_bits = ^{bus.instr_d[31], bus.instr_d[29:25]};

  // ALU operation from funct3; sub only for R-type, never for addi.
  always_comb begin
    w_alufn = ALU_ADD;
    case (w_f3)
      3'b000: w_alufn = (w_is_r && w_f7b5) ? ALU_SUB : ALU_ADD;
      3'b001: w_alufn = ALU_SLL;
      3'b010: w_alufn = ALU_SLT;
      3'b011: w_alufn = ALU_SLT;
      3'b100: w_alufn = ALU_XOR;
      3'b101: w_alufn = w_f7b5 ? ALU_SRA : ALU_SRL;
      3'b110: w_alufn = ALU_OR;
      3'b111: w_alufn = ALU_AND;
      default: w_alufn = ALU_ADD;
    endcase
  end

  // Main decoder: control word, immediate format and source-register use.
  always_comb begin
    w_ctrl_d     = '0;
    w_ctrl_d.rd  = bus.instr_d[11:7];
    w_ctrl_d.rs1 = bus.instr_d[19:15];
    w_ctrl_d.rs2 = bus.instr_d[24:20];
    w_immsrc_d   = 3'b000;
    w_use_rs1_d  = 1'b0;
    w_use_rs2_d  = 1'b0;
    case (w_op)
      OP_LW: begin
        w_ctrl_d.regwrite  = 1'b1;
        w_ctrl_d.resultsrc = 2'b01;
        w_ctrl_d.alusrc    = 1'b1;
        w_ctrl_d.aluctrl   = ALU_ADD;
        w_immsrc_d         = 3'b000;
        w_use_rs1_d        = 1'b1;
      end
      OP_SW: begin
        w_ctrl_d.memwrite = 1'b1;
        w_ctrl_d.alusrc   = 1'b1;
        w_ctrl_d.aluctrl  = ALU_ADD;
        w_immsrc_d        = 3'b001;
        w_use_rs1_d       = 1'b1;
        w_use_rs2_d       = 1'b1;
      end
      OP_R: begin
        w_ctrl_d.regwrite = 1'b1;
        w_ctrl_d.aluctrl  = w_alufn;
        w_use_rs1_d       = 1'b1;
        w_use_rs2_d       = 1'b1;
      end
      OP_I: begin
        w_ctrl_d.regwrite = 1'b1;
        w_ctrl_d.alusrc   = 1'b1;
        w_ctrl_d.aluctrl  = w_alufn;
        w_immsrc_d        = 3'b000;
        w_use_rs1_d       = 1'b1;
      end
      OP_BEQ: begin
        w_ctrl_d.branch  = 1'b1;
        w_ctrl_d.aluctrl = ALU_SUB;
        w_immsrc_d       = 3'b010;
        w_use_rs1_d      = 1'b1;
        w_use_rs2_d      = 1'b1;
      end
      OP_JAL: begin
        w_ctrl_d.regwrite  = 1'b1;
        w_ctrl_d.jump      = 1'b1;
        w_ctrl_d.resultsrc = 2'b10;
        w_immsrc_d         = 3'b011;
      end
      OP_LUI: begin
        w_ctrl_d.regwrite = 1'b1;
        w_ctrl_d.alusrc   = 1'b1;
        w_ctrl_d.aluctrl  = ALU_PASSB;
        w_immsrc_d        = 3'b100;
      end
      default: begin
        w_ctrl_d.illegal = 1'b1;
      end
    endcase
  end

  // Redirect and load-use hazard; a taken redirect suppresses the stall so
  // the target fetch proceeds.
  assign w_pcsrc_e = (r_ctrl_e.branch & bus.zero_e) | r_ctrl_e.jump;
  assign w_lwstall = (r_ctrl_e.resultsrc == 2'b01) && (r_ctrl_e.rd != 5'd0) &&
                     ((w_use_rs1_d && (w_ctrl_d.rs1 == r_ctrl_e.rd)) ||
                      (w_use_rs2_d && (w_ctrl_d.rs2 == r_ctrl_e.rd))) &&
                     !w_pcsrc_e;
  assign w_bubble  = w_lwstall | w_pcsrc_e;

  // ID/EX register: bubble on stall or redirect, otherwise load from D.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_ctrl_e <= '0;
    else if (w_bubble) r_ctrl_e <= '0;
    else               r_ctrl_e <= w_ctrl_d;
  end

  // EX/MEM and MEM/WB registers advance every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regwrite_m  <= 1'b0;
      r_resultsrc_m <= 2'b00;
      r_memwrite_m  <= 1'b0;
      r_rd_m        <= 5'd0;
      r_regwrite_w  <= 1'b0;
      r_resultsrc_w <= 2'b00;
      r_rd_w        <= 5'd0;
    end else begin
      r_regwrite_m  <= r_ctrl_e.regwrite;
      r_resultsrc_m <= r_ctrl_e.resultsrc;
      r_memwrite_m  <= r_ctrl_e.memwrite;
      r_rd_m        <= r_ctrl_e.rd;
      r_regwrite_w  <= r_regwrite_m;
      r_resultsrc_w <= r_resultsrc_m;
      r_rd_w        <= r_rd_m;
    end
  end

  // Forwarding selects: M has priority over W, x0 is never forwarded.
  if (FWD_EN != 0) begin : g_fwd
    always_comb begin
      bus.fwd_a_e = 2'b00;
      bus.fwd_b_e = 2'b00;
      if (r_regwrite_m && (r_rd_m != 5'd0) && (r_rd_m == r_ctrl_e.rs1))      bus.fwd_a_e = 2'b10;
      else if (r_regwrite_w && (r_rd_w != 5'd0) && (r_rd_w == r_ctrl_e.rs1)) bus.fwd_a_e = 2'b01;
      if (r_regwrite_m && (r_rd_m != 5'd0) && (r_rd_m == r_ctrl_e.rs2))      bus.fwd_b_e = 2'b10;
      else if (r_regwrite_w && (r_rd_w != 5'd0) && (r_rd_w == r_ctrl_e.rs2)) bus.fwd_b_e = 2'b01;
    end
  end else begin : g_nofwd
    assign bus.fwd_a_e = 2'b00;
    assign bus.fwd_b_e = 2'b00;
  end

  assign bus.immsrc_d     = IMMSRC_W'(w_immsrc_d);
  assign bus.regwrite_e   = r_ctrl_e.regwrite;
  assign bus.regwrite_m   = r_regwrite_m;
  assign bus.regwrite_w   = r_regwrite_w;
  assign bus.resultsrc_e  = r_ctrl_e.resultsrc;
  assign bus.resultsrc_m  = r_resultsrc_m;
  assign bus.resultsrc_w  = r_resultsrc_w;
  assign bus.memwrite_e   = r_ctrl_e.memwrite;
  assign bus.memwrite_m   = r_memwrite_m;
  assign bus.alusrc_e     = r_ctrl_e.alusrc;
  assign bus.alucontrol_e = ALUCTRL_W'(r_ctrl_e.aluctrl);
  assign bus.pcsrc_e      = w_pcsrc_e;
  assign bus.rd_e         = r_ctrl_e.rd;
  assign bus.rd_m         = r_rd_m;
  assign bus.rd_w         = r_rd_w;
  assign bus.rs1_e        = r_ctrl_e.rs1;
  assign bus.rs2_e        = r_ctrl_e.rs2;
  assign bus.illegal_e    = r_ctrl_e.illegal;
  assign bus.stall_f      = w_lwstall;
  assign bus.stall_d      = w_lwstall;
  assign bus.flush_d      = w_pcsrc_e;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Bench for pipe_control_unit: directed instruction sequences, expected
// per-field values queued with their due cycle, checked by a monitor.
module tb_pipe_control_unit;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  int unsigned cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  pipe_control_unit_if #(.ALUCTRL_W(4), .IMMSRC_W(3)) bus ();

  pipe_control_unit #(.ALUCTRL_W(4), .IMMSRC_W(3), .FWD_EN(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- fields under check ----------------
  localparam int F_REGWRITE_E = 0,  F_REGWRITE_M = 1,  F_REGWRITE_W = 2;
  localparam int F_RESULTSRC_E = 3, F_RESULTSRC_W = 4, F_MEMWRITE_E = 5;
  localparam int F_MEMWRITE_M = 6,  F_ALUSRC_E = 7,    F_ALUCTRL_E = 8;
  localparam int F_PCSRC_E = 9,     F_RD_E = 10,       F_RD_M = 11;
  localparam int F_RD_W = 12,       F_RS1_E = 13,      F_RS2_E = 14;
  localparam int F_ILLEGAL_E = 15,  F_STALL_F = 16,    F_STALL_D = 17;
  localparam int F_FLUSH_D = 18,    F_FWD_A = 19,      F_FWD_B = 20;
  localparam int F_IMMSRC_D = 21,   F_ALLREG = 22,     F_HAZ = 23;

  function automatic logic [63:0] get_field(input int id);
    case (id)
      F_REGWRITE_E:  return 64'(bus.regwrite_e);
      F_REGWRITE_M:  return 64'(bus.regwrite_m);
      F_REGWRITE_W:  return 64'(bus.regwrite_w);
      F_RESULTSRC_E: return 64'(bus.resultsrc_e);
      F_RESULTSRC_W: return 64'(bus.resultsrc_w);
      F_MEMWRITE_E:  return 64'(bus.memwrite_e);
      F_MEMWRITE_M:  return 64'(bus.memwrite_m);
      F_ALUSRC_E:    return 64'(bus.alusrc_e);
      F_ALUCTRL_E:   return 64'(bus.alucontrol_e);
      F_PCSRC_E:     return 64'(bus.pcsrc_e);
      F_RD_E:        return 64'(bus.rd_e);
      F_RD_M:        return 64'(bus.rd_m);
      F_RD_W:        return 64'(bus.rd_w);
      F_RS1_E:       return 64'(bus.rs1_e);
      F_RS2_E:       return 64'(bus.rs2_e);
      F_ILLEGAL_E:   return 64'(bus.illegal_e);
      F_STALL_F:     return 64'(bus.stall_f);
      F_STALL_D:     return 64'(bus.stall_d);
      F_FLUSH_D:     return 64'(bus.flush_d);
      F_FWD_A:       return 64'(bus.fwd_a_e);
      F_FWD_B:       return 64'(bus.fwd_b_e);
      F_IMMSRC_D:    return 64'(bus.immsrc_d);
      F_ALLREG:      return 64'({bus.regwrite_e, bus.regwrite_m, bus.regwrite_w,
                                 bus.resultsrc_e, bus.resultsrc_m, bus.resultsrc_w,
                                 bus.memwrite_e, bus.memwrite_m, bus.alusrc_e,
                                 bus.alucontrol_e, bus.rd_e, bus.rd_m, bus.rd_w,
                                 bus.rs1_e, bus.rs2_e, bus.illegal_e});
      F_HAZ:         return 64'({bus.pcsrc_e, bus.stall_f, bus.stall_d, bus.flush_d,
                                 bus.fwd_a_e, bus.fwd_b_e});
      default:       return 64'hDEAD_BEEF_DEAD_BEEF;
    endcase
  endfunction

  function automatic string fname(input int id);
    case (id)
      F_REGWRITE_E:  return "regwrite_e";
      F_REGWRITE_M:  return "regwrite_m";
      F_REGWRITE_W:  return "regwrite_w";
      F_RESULTSRC_E: return "resultsrc_e";
      F_RESULTSRC_W: return "resultsrc_w";
      F_MEMWRITE_E:  return "memwrite_e";
      F_MEMWRITE_M:  return "memwrite_m";
      F_ALUSRC_E:    return "alusrc_e";
      F_ALUCTRL_E:   return "alucontrol_e";
      F_PCSRC_E:     return "pcsrc_e";
      F_RD_E:        return "rd_e";
      F_RD_M:        return "rd_m";
      F_RD_W:        return "rd_w";
      F_RS1_E:       return "rs1_e";
      F_RS2_E:       return "rs2_e";
      F_ILLEGAL_E:   return "illegal_e";
      F_STALL_F:     return "stall_f";
      F_STALL_D:     return "stall_d";
      F_FLUSH_D:     return "flush_d";
      F_FWD_A:       return "fwd_a_e";
      F_FWD_B:       return "fwd_b_e";
      F_IMMSRC_D:    return "immsrc_d";
      F_ALLREG:      return "all_registered";
      F_HAZ:         return "hazard_bundle";
      default:       return "unknown";
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    int unsigned cyc;
    int          id;
    logic [63:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Queue kept ordered by due cycle.
  task automatic push_exp(input int dc, input int id, input logic [63:0] v);
    exp_t e;
    int   pos;
    e.cyc = cyc + dc;
    e.id  = id;
    e.val = v;
    pos = exp_q.size();
    for (int k = 0; k < exp_q.size(); k++) begin
      if (exp_q[k].cyc > e.cyc) begin
        pos = k;
        break;
      end
    end
    exp_q.insert(pos, e);
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the update edge.
  exp_t        m_e;
  logic [63:0] m_got;
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      m_e   = exp_q.pop_front();
      m_got = get_field(m_e.id);
      total = total + 1;
      if (m_e.cyc != cyc || m_got !== m_e.val) begin
        bad = bad + 1;
        $display("FAIL %s cycle=%0d due=%0d got=%0h want=%0h",
                 fname(m_e.id), cyc, m_e.cyc, m_got, m_e.val);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins, input logic z);
    bus.instr_d = ins;
    bus.zero_e  = z;
  endtask

  localparam logic [31:0] I_NOP      = 32'h0000_0013;
  localparam logic [31:0] I_ADD3     = 32'h0020_81B3; // add x3,x1,x2
  localparam logic [31:0] I_SUB8     = 32'h4020_8433; // sub x8,x1,x2
  localparam logic [31:0] I_ADDI_B30 = 32'h4000_0093; // addi x1,x0,0x400
  localparam logic [31:0] I_XOR      = 32'h0010_C0B3; // xor x1,x1,x1
  localparam logic [31:0] I_SW       = 32'h0020_A223; // sw x2,4(x1)
  localparam logic [31:0] I_LW5      = 32'h0000_A283; // lw x5,0(x1)
  localparam logic [31:0] I_ADD6_55  = 32'h0052_8333; // add x6,x5,x5
  localparam logic [31:0] I_BEQ      = 32'h0000_0463; // beq x0,x0,8
  localparam logic [31:0] I_JAL      = 32'h0080_00EF; // jal x1,8
  localparam logic [31:0] I_ADD4     = 32'h0020_8233; // add x4,x1,x2
  localparam logic [31:0] I_ADD7_40  = 32'h0002_03B3; // add x7,x4,x0
  localparam logic [31:0] I_ADD0     = 32'h0020_8033; // add x0,x1,x2
  localparam logic [31:0] I_ADD7_00  = 32'h0000_03B3; // add x7,x0,x0
  localparam logic [31:0] I_BAD      = 32'h0000_007F;
  localparam logic [31:0] I_SRAI     = 32'h4031_5093; // srai x1,x2,3
  localparam logic [31:0] I_SRLI     = 32'h0031_5093; // srli x1,x2,3
  localparam logic [31:0] I_LUI      = 32'h1234_54B7; // lui x9,0x12345

  // ---------------- stimulus ----------------
  initial begin
    cyc   = 0;
    rst_n = 1'b0;
    issue(32'h0, 1'b0);
    tick();

    // Reset with random instructions in D.
    for (int k = 0; k < 3; k++) begin
      issue($urandom, 1'($urandom_range(0, 1)));
      push_exp(0, F_ALLREG, 64'd0);
      push_exp(0, F_HAZ, 64'd0);
      tick();
    end
    rst_n = 1'b1;
    issue(I_NOP, 1'b0);
    tick();

    // Basic R-type flow and ALU encodings.
    issue(I_ADD3, 1'b0);
    push_exp(1, F_REGWRITE_E, 64'd1);
    push_exp(1, F_ALUCTRL_E, 64'd0);
    push_exp(1, F_RD_E, 64'd3);
    push_exp(1, F_RS1_E, 64'd1);
    push_exp(1, F_RS2_E, 64'd2);
    push_exp(2, F_RD_M, 64'd3);
    push_exp(3, F_RD_W, 64'd3);
    push_exp(3, F_REGWRITE_W, 64'd1);
    tick();
    issue(I_SUB8, 1'b0);
    push_exp(1, F_ALUCTRL_E, 64'd1);
    tick();
    issue(I_ADDI_B30, 1'b0);
    push_exp(1, F_ALUCTRL_E, 64'd0);
    push_exp(1, F_ALUSRC_E, 64'd1);
    tick();
    issue(I_XOR, 1'b0);
    push_exp(1, F_ALUCTRL_E, 64'd4);
    push_exp(1, F_ALUSRC_E, 64'd0);
    tick();
    issue(I_SW, 1'b0);
    push_exp(0, F_IMMSRC_D, 64'd1);
    push_exp(1, F_MEMWRITE_E, 64'd1);
    push_exp(1, F_REGWRITE_E, 64'd0);
    push_exp(2, F_MEMWRITE_M, 64'd1);
    tick();

    // Load-use: one stall cycle, bubble in E, then forward from W.
    issue(I_LW5, 1'b0);
    push_exp(1, F_RESULTSRC_E, 64'd1);
    push_exp(1, F_STALL_F, 64'd1);
    push_exp(1, F_STALL_D, 64'd1);
    tick();
    issue(I_ADD6_55, 1'b0);
    push_exp(1, F_REGWRITE_E, 64'd0);
    push_exp(1, F_RD_E, 64'd0);
    push_exp(1, F_STALL_F, 64'd0);
    push_exp(1, F_RD_M, 64'd5);
    tick();
    issue(I_ADD6_55, 1'b0);
    push_exp(1, F_RD_E, 64'd6);
    push_exp(1, F_FWD_A, 64'd1);
    push_exp(1, F_FWD_B, 64'd1);
    tick();

    // Taken branch flushes D and bubbles E.
    issue(I_BEQ, 1'b0);
    push_exp(0, F_IMMSRC_D, 64'd2);
    tick();
    issue(I_ADD6_55, 1'b1);
    push_exp(0, F_PCSRC_E, 64'd1);
    push_exp(0, F_FLUSH_D, 64'd1);
    push_exp(0, F_STALL_F, 64'd0);
    push_exp(1, F_REGWRITE_E, 64'd0);
    push_exp(1, F_RD_E, 64'd0);
    push_exp(1, F_PCSRC_E, 64'd0);
    tick();

    // Not-taken branch lets the next instruction through.
    issue(I_BEQ, 1'b0);
    tick();
    issue(I_ADD6_55, 1'b0);
    push_exp(0, F_PCSRC_E, 64'd0);
    push_exp(0, F_FLUSH_D, 64'd0);
    push_exp(1, F_RD_E, 64'd6);
    tick();

    // jal redirects regardless of zero_e and writes PC+4.
    issue(I_JAL, 1'b0);
    push_exp(0, F_IMMSRC_D, 64'd3);
    push_exp(1, F_PCSRC_E, 64'd1);
    push_exp(1, F_RESULTSRC_E, 64'd2);
    push_exp(1, F_REGWRITE_E, 64'd1);
    push_exp(3, F_RESULTSRC_W, 64'd2);
    tick();
    issue(I_NOP, 1'b0);
    push_exp(1, F_REGWRITE_E, 64'd0);
    tick();

    // Forwarding priority M over W, and x0 never forwarded.
    issue(I_ADD4, 1'b0);
    tick();
    issue(I_ADD4, 1'b0);
    tick();
    issue(I_ADD7_40, 1'b0);
    push_exp(1, F_FWD_A, 64'd2);
    push_exp(1, F_FWD_B, 64'd0);
    tick();
    issue(I_ADD0, 1'b0);
    tick();
    issue(I_NOP, 1'b0);
    tick();
    issue(I_ADD7_00, 1'b0);
    push_exp(1, F_FWD_A, 64'd0);
    push_exp(1, F_FWD_B, 64'd0);
    tick();

    // Illegal opcode, shifts, lui.
    issue(I_BAD, 1'b0);
    push_exp(0, F_IMMSRC_D, 64'd0);
    push_exp(1, F_ILLEGAL_E, 64'd1);
    push_exp(1, F_REGWRITE_E, 64'd0);
    push_exp(1, F_MEMWRITE_E, 64'd0);
    push_exp(1, F_ALUSRC_E, 64'd0);
    push_exp(1, F_RESULTSRC_E, 64'd0);
    tick();
    issue(I_SRAI, 1'b0);
    push_exp(1, F_ALUCTRL_E, 64'd8);
    push_exp(1, F_ILLEGAL_E, 64'd0);
    push_exp(1, F_ALUSRC_E, 64'd1);
    tick();
    issue(I_SRLI, 1'b0);
    push_exp(1, F_ALUCTRL_E, 64'd7);
    tick();
    issue(I_LUI, 1'b0);
    push_exp(0, F_IMMSRC_D, 64'd4);
    push_exp(1, F_ALUCTRL_E, 64'd9);
    push_exp(1, F_ALUSRC_E, 64'd1);
    push_exp(1, F_REGWRITE_E, 64'd1);
    tick();

    // Asynchronous reset mid-flight discards all in-flight control.
    issue(I_ADD3, 1'b0);
    tick();
    issue(I_NOP, 1'b0);
    rst_n = 1'b0;
    push_exp(0, F_ALLREG, 64'd0);
    push_exp(0, F_HAZ, 64'd0);
    tick();
    issue(I_BAD, 1'b0);
    rst_n = 1'b1;
    push_exp(0, F_ALLREG, 64'd0);
    push_exp(1, F_REGWRITE_M, 64'd0);
    push_exp(1, F_REGWRITE_W, 64'd0);
    push_exp(1, F_ILLEGAL_E, 64'd1);
    tick();
    issue(I_NOP, 1'b0);

    // Drain outstanding expectations within a bounded number of cycles.
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) tick();
    if (exp_q.size() > 0) begin
      $display("FAIL drain pending=%0d want=0", exp_q.size());
      bad = bad + exp_q.size();
    end

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
